load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Write-side partner of the register file for memory instructions: takes one RV32I
//  load/store request per transaction and runs a valid/ready handshake to data memory.
//  For loads it aligns and extends the read data, then drives one register-file write
//  (wb_we/wb_addr/wb_data).
//  Sits between execute (address already computed) and the regfile write port.
// PARAMETERS
//  WIDTH  32  data/address width; fixed at 32 (4 byte lanes), other values unsupported
// PORTS
//  clk           in   1      single clock, all state updates on posedge
//  rst_n         in   1      asynchronous active-low reset
//  req_valid     in   1      request present
//  req_ready     out  1      unit can accept request (high only in IDLE)
//  req_load      in   1      1 = load, 0 = store
//  req_funct3    in   3      RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  req_addr      in   WIDTH  byte address
//  req_wdata     in   WIDTH  store data (rs2), low bytes used for SB/SH
//  req_rd        in   5      load destination register
//  mem_valid     out  1      memory request valid
//  mem_ready     in   1      memory accepts request
//  mem_we        out  1      1 = write
//  mem_addr      out  WIDTH  word-aligned address {req_addr[31:2],2'b00}
//  mem_wstrb     out  4      byte-lane write enables
//  mem_wdata     out  WIDTH  lane-replicated store data
//  mem_rvalid    in   1      read data valid
//  mem_rdata     in   WIDTH  read word
//  wb_we         out  1      regfile write enable, one-cycle pulse
//  wb_addr       out  5      regfile write address
//  wb_data       out  WIDTH  regfile write data
//  done          out  1      one-cycle pulse: transaction finished (store accepted / load written back)
//  err           out  1      one-cycle pulse: misaligned or illegal funct3, request dropped
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1 after reset release; all other outputs 0; latched request cleared.
//  FSM IDLE -> REQ -> (store) IDLE | (load) WAIT_R -> WB -> IDLE.
//   IDLE:   accept on req_valid&req_ready. Misaligned (H: addr[0]!=0; W: addr[1:0]!=0) or
//           illegal funct3 (load 011/110/111, store >=011): err=1 next cycle, stay IDLE,
//           no memory access. Otherwise latch all req_* fields and go REQ.
//   REQ:    mem_valid=1; mem_we/addr/wstrb/wdata registered, stable until mem_ready.
//           On mem_valid&mem_ready: store -> IDLE with done=1 next cycle; load -> WAIT_R.
//   WAIT_R: mem_valid=0; wait any number of cycles for mem_rvalid; mem_rvalid is ignored
//           outside WAIT_R. On rvalid capture extended data, go WB.
//   WB:     wb_we=1 for exactly one cycle unless rd==0 (wb_we=0, done still pulses);
//           wb_addr/wb_data held valid in that cycle; done=1; next state IDLE.
//  Latency (zero-wait memory): store accept->done 2 cycles; load accept->wb_we 3 cycles + rvalid delay.
//  Stores: SB wstrb=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}; SH wstrb=addr[1]?1100:0011,
//   wdata={2{wdata[15:0]}}; SW wstrb=1111, wdata=req_wdata. Loads: mem_wstrb=0.
//  Loads: select byte/half by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough.
//  Back-to-back: new request accepted no earlier than the cycle after returning to IDLE.
//  Reset mid-transaction: immediate return to IDLE, mem_valid/wb_we drop asynchronously,
//   outstanding memory response discarded (memory side must be reset together).
// STRUCTURE
//  rv32_pkg: funct3 constants (F3_B/H/W/BU/HU), lsu_state_t enum {IDLE,REQ,WAIT_R,WB}.
//  Sub-module lsu_load_align: combinational (rdata, addr[1:0], funct3) -> extended WIDTH data;
//   store lane/strobe generation stays in this module.
// TESTING
//  1 SW addr 0x100 data 0xDEADBEEF, mem_ready=1 -> mem_wstrb=1111, mem_addr=0x100, done 2 cycles after accept.
//  2 SB addr 0x103 data 0x000000A5 -> wstrb=1000, wdata=0xA5A5A5A5; SH addr 0x102 -> wstrb=1100.
//  3 LB addr 0x101 rdata 0x0000_80FF rd=5 -> wb_we pulse, wb_addr=5, wb_data=0xFFFFFF80; LBU -> 0x00000080.
//  4 LH addr 0x001 -> err pulse, mem_valid never asserts, req_ready stays 1; LW rd=0 -> done, wb_we=0.
//  5 mem_ready low 3 cycles then high, rvalid 4 cycles later -> mem_* stable while stalled, one write only.
//  6 rst_n low during WAIT_R -> all outputs 0, IDLE; late mem_rvalid ignored; next LW completes.

Source files
------------

// File: rtl/rv32_pkg.sv
// RV32I load/store shared definitions: funct3 codes, LSU state encoding
// and request legality helpers.
package rv32_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R,
    WB
  } lsu_state_t;

  function automatic logic f3_legal(
    input logic       load,
    input logic [2:0] f3
  );
    if (load)
      return (f3 == F3_B) || (f3 == F3_H) ||
             (f3 == F3_W) || (f3 == F3_BU) ||
             (f3 == F3_HU);
    return f3 < 3'b011;
  endfunction

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    unique case (1'b1)
      f3[1:0] == 2'b01: return off[0];
      f3[1:0] == 2'b10: return off != 2'b00;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks byte/half from the read word and extends it.
// Ports: rdata (memory word), off (addr[1:0]), funct3 -> ext (WIDTH).
module lsu_load_align
  import rv32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rdata,
  input  logic [1:0]       off,
  input  logic [2:0]       funct3,
  output logic [WIDTH-1:0] ext
);

  logic [WIDTH-1:0] sh;

  assign sh = rdata >> {off, 3'b000};

  always_comb begin
    ext = sh;
    unique case (funct3)
      F3_B:    ext = {{(WIDTH-8){sh[7]}}, sh[7:0]};
      F3_H:    ext = {{(WIDTH-16){sh[15]}}, sh[15:0]};
      F3_BU:   ext = {{(WIDTH-8){1'b0}}, sh[7:0]};
      F3_HU:   ext = {{(WIDTH-16){1'b0}}, sh[15:0]};
      default: ext = sh;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: request handshake, data-memory valid/ready
// access, load alignment and one regfile write per load.
module load_store_unit
  import rv32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_load,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [4:0]       req_rd,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_wstrb,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             wb_we,
  output logic [4:0]       wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic             done,
  output logic             err
);

  lsu_state_t       state;
  lsu_state_t       state_nxt;
  logic             load_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic [4:0]       rd_q;
  logic [WIDTH-3:0] waddr_q;
  logic [3:0]       strb_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] wb_data_q;
  logic             sdone_q;
  logic             err_q;
  logic             accept;
  logic             bad;
  logic [3:0]       strb_c;
  logic [WIDTH-1:0] lane_c;
  logic [WIDTH-1:0] ext;
  logic             in_req;
  logic             in_wb;

  assign in_req    = state == REQ;
  assign in_wb     = state == WB;
  assign req_ready = rst_n & (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign bad       = ~f3_legal(req_load, req_funct3) |
                     misaligned(req_funct3, req_addr[1:0]);

  always_comb begin
    strb_c = 4'b0000;
    lane_c = '0;
    if (!req_load) begin
      unique case (req_funct3[1:0])
        2'b00: begin
          strb_c = 4'b0001 << req_addr[1:0];
          lane_c = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          strb_c = req_addr[1] ? 4'b1100 : 4'b0011;
          lane_c = {2{req_wdata[15:0]}};
        end
        default: begin
          strb_c = 4'b1111;
          lane_c = req_wdata;
        end
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept && !bad) state_nxt = REQ;
      REQ:     if (mem_ready) state_nxt = load_q ? WAIT_R : IDLE;
      WAIT_R:  if (mem_rvalid) state_nxt = WB;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      load_q    <= 1'b0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      rd_q      <= 5'd0;
      waddr_q   <= '0;
      strb_q    <= 4'b0000;
      wdata_q   <= '0;
      wb_data_q <= '0;
      sdone_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state   <= state_nxt;
      err_q   <= accept & bad;
      sdone_q <= in_req & mem_ready & ~load_q;
      if (accept && !bad) begin
        load_q  <= req_load;
        f3_q    <= req_funct3;
        off_q   <= req_addr[1:0];
        rd_q    <= req_rd;
        waddr_q <= req_addr[WIDTH-1:2];
        strb_q  <= strb_c;
        wdata_q <= lane_c;
      end
      if (state == WAIT_R && mem_rvalid)
        wb_data_q <= ext;
    end
  end

  lsu_load_align #(.WIDTH(WIDTH)) u_align (
    .rdata  (mem_rdata),
    .off    (off_q),
    .funct3 (f3_q),
    .ext    (ext)
  );

  // Memory-side outputs are qualified by REQ so they read 0 when idle.
  assign mem_valid = in_req;
  assign mem_we    = in_req & ~load_q;
  assign mem_addr  = in_req ? {waddr_q, 2'b00} : '0;
  assign mem_wstrb = in_req ? strb_q : 4'b0000;
  assign mem_wdata = in_req ? wdata_q : '0;

  assign wb_we   = in_wb & (rd_q != 5'd0);
  assign wb_addr = in_wb ? rd_q : 5'd0;
  assign wb_data = in_wb ? wb_data_q : '0;
  assign done    = sdone_q | in_wb;
  assign err     = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed spec cases plus
// randomized transactions against a byte-level reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_load   (req_load),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .done       (done),
    .err        (err)
  );

  // Drives one transaction acting as memory and checks every cycle
  // against values derived from byte-lane arithmetic.
  task automatic run_txn(
    input bit          ld,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input logic [4:0]  rd,
    input int          rdly,
    input int          vdly,
    input logic [31:0] rdata
  );
    int          off;
    int          n;
    bit          legal;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [31:0] e_wb;
    longint      v;
    off = int'(addr % 4);
    n = 1 << f3[1:0];
    if (ld)
      legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    else
      legal = f3 < 3;
    if (legal && (addr % n) != 0) legal = 0;
    e_strb = 4'b0000;
    e_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (!ld && legal && i >= off && i < off + n) e_strb[i] = 1'b1;
      if (!ld && legal) e_wdata[8*i +: 8] = wd[8*(i % n) +: 8];
    end
    v = longint'(rdata) >>> (8 * off);
    if (n < 4) begin
      v = v & ((64'sd1 << (8 * n)) - 1);
      if (!f3[2] && ((v >> (8 * n - 1)) & 1) == 1) v = v - (64'sd1 << (8 * n));
    end
    e_wb = v[31:0];

    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_idle got %b want 1", req_ready);
    end
    req_valid = 1'b1;
    req_load = ld;
    req_funct3 = f3;
    req_addr = addr;
    req_wdata = wd;
    req_rd = rd;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr = $urandom;
    req_wdata = $urandom;
    if (!legal) begin
      checks++;
      if (err !== 1'b1 || mem_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL err_pulse got err=%b mv=%b rr=%b want 1 0 1",
                 err, mem_valid, req_ready);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || mem_valid !== 1'b0) begin
        errors++;
        $display("FAIL err_end got err=%b mv=%b want 0 0", err, mem_valid);
      end
      return;
    end
    for (int k = 0; k <= rdly; k++) begin
      checks++;
      if (mem_valid !== 1'b1 || mem_we !== !ld ||
          mem_addr !== {addr[31:2], 2'b00} ||
          mem_wstrb !== e_strb || mem_wdata !== e_wdata) begin
        errors++;
        $display("FAIL mem_req got v=%b we=%b a=%h s=%b d=%h want 1 %b %h %b %h",
                 mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
                 !ld, {addr[31:2], 2'b00}, e_strb, e_wdata);
      end
      mem_ready = (k == rdly);
      mem_rvalid = $urandom_range(0, 1);
      mem_rdata = $urandom;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    if (!ld) begin
      checks++;
      if (done !== 1'b1 || mem_valid !== 1'b0 || wb_we !== 1'b0) begin
        errors++;
        $display("FAIL store_done got done=%b mv=%b we=%b want 1 0 0",
                 done, mem_valid, wb_we);
      end
    end else begin
      for (int j = 0; j < vdly; j++) begin
        checks++;
        if (mem_valid !== 1'b0 || wb_we !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL wait_r got mv=%b we=%b done=%b want 0 0 0",
                   mem_valid, wb_we, done);
        end
        @(negedge clk);
      end
      mem_rvalid = 1'b1;
      mem_rdata = rdata;
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata = $urandom;
      checks++;
      if (wb_we !== (rd != 0) || done !== 1'b1 ||
          (rd != 0 && (wb_addr !== rd || wb_data !== e_wb))) begin
        errors++;
        $display("FAIL load_wb got we=%b a=%0d d=%h done=%b want %b %0d %h 1",
                 wb_we, wb_addr, wb_data, done, rd != 0, rd, e_wb);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || wb_we !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL txn_end got done=%b we=%b rr=%b want 0 0 1",
               done, wb_we, req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_load = 1'b0;
    req_funct3 = 3'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    req_rd = 5'd0;
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || mem_valid !== 1'b0 || mem_we !== 1'b0 ||
        mem_addr !== 32'h0 || mem_wstrb !== 4'h0 || mem_wdata !== 32'h0 ||
        wb_we !== 1'b0 || wb_addr !== 5'd0 || wb_data !== 32'h0 ||
        done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got rr=%b mv=%b we=%b wbwe=%b done=%b err=%b",
               req_ready, mem_valid, mem_we, wb_we, done, err);
    end
  endtask

  task automatic test_store();
    run_txn(0, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 0, 0, 32'h0);
    run_txn(0, 3'b000, 32'h103, 32'h000000A5, 5'd0, 0, 0, 32'h0);
    run_txn(0, 3'b001, 32'h102, 32'h1234BEEF, 5'd0, 0, 0, 32'h0);
    run_txn(0, 3'b001, 32'h200, 32'h1234BEEF, 5'd0, 1, 0, 32'h0);
  endtask

  task automatic test_load();
    run_txn(1, 3'b000, 32'h101, 32'h0, 5'd5, 0, 0, 32'h000080FF);
    run_txn(1, 3'b100, 32'h101, 32'h0, 5'd5, 0, 0, 32'h000080FF);
    run_txn(1, 3'b001, 32'h102, 32'h0, 5'd7, 0, 1, 32'h9ABC0000);
    run_txn(1, 3'b101, 32'h102, 32'h0, 5'd7, 0, 0, 32'h9ABC0000);
    run_txn(1, 3'b010, 32'h104, 32'h0, 5'd31, 0, 0, 32'hCAFEF00D);
  endtask

  task automatic test_err();
    run_txn(1, 3'b001, 32'h001, 32'h0, 5'd3, 0, 0, 32'h0);
    run_txn(0, 3'b010, 32'h102, 32'h0, 5'd0, 0, 0, 32'h0);
    run_txn(1, 3'b011, 32'h100, 32'h0, 5'd3, 0, 0, 32'h0);
    run_txn(0, 3'b100, 32'h100, 32'h0, 5'd0, 0, 0, 32'h0);
    run_txn(1, 3'b010, 32'h108, 32'h0, 5'd0, 0, 0, 32'h11223344);
  endtask

  task automatic test_stall();
    run_txn(1, 3'b010, 32'h300, 32'h0, 5'd9, 3, 4, 32'h55AA33CC);
    run_txn(0, 3'b000, 32'h301, 32'h77, 5'd0, 3, 0, 32'h0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1;
    req_load = 1'b1;
    req_funct3 = 3'b010;
    req_addr = 32'h400;
    req_rd = 5'd4;
    @(negedge clk);
    req_valid = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_valid !== 1'b0 || wb_we !== 1'b0 || done !== 1'b0 ||
        err !== 1'b0 || mem_wstrb !== 4'h0 || wb_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid got mv=%b we=%b done=%b err=%b want 0 0 0 0",
               mem_valid, wb_we, done, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    checks++;
    if (wb_we !== 1'b0 || done !== 1'b0 || mem_valid !== 1'b0 ||
        req_ready !== 1'b1) begin
      errors++;
      $display("FAIL late_rvalid got we=%b done=%b mv=%b rr=%b want 0 0 0 1",
               wb_we, done, mem_valid, req_ready);
    end
    run_txn(1, 3'b010, 32'h404, 32'h0, 5'd6, 0, 0, 32'h0BADF00D);
  endtask

  task automatic test_random();
    logic [2:0] f3;
    for (int t = 0; t < 60; t++) begin
      f3 = 3'($urandom_range(0, 7));
      run_txn(bit'($urandom_range(0, 1)), f3,
              32'($urandom_range(0, 255)), $urandom,
              5'($urandom_range(0, 31)),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_err();
    test_stall();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
